// File: rtl/mem_stage_oq_if.sv
// mem_stage_oq_if: EX->MEM push and MEM->WB pop handshakes.
// master drives instructions and out_ready; slave is the stage.
interface mem_stage_oq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic        in_req;
  logic [4:0]  in_load_op;
  logic [31:0] in_result;
  logic        in_rf_we;
  logic [4:0]  in_rf_waddr;
  logic        in_ex;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic        out_rf_we;
  logic [4:0]  out_rf_waddr;
  logic [31:0] out_rf_wdata;
  logic        out_ex;

  modport master (
    output in_valid, in_pc, in_req, in_load_op,
    output in_result, in_rf_we, in_rf_waddr, in_ex,
    output out_ready,
    input  in_ready, out_valid, out_pc, out_rf_we,
    input  out_rf_waddr, out_rf_wdata, out_ex
  );

  modport slave (
    input  in_valid, in_pc, in_req, in_load_op,
    input  in_result, in_rf_we, in_rf_waddr, in_ex,
    input  out_ready,
    output in_ready, out_valid, out_pc, out_rf_we,
    output out_rf_waddr, out_rf_wdata, out_ex
  );
endinterface

// File: rtl/mem_stage_oq.sv
// mem_stage_oq: in-order MEM queue matching data_ok to requests.
// Extracts load data for WB; discards responses after a flush.
module mem_stage_oq #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic          clk,
  input  logic          reset,
  mem_stage_oq_if.slave io,
  input  logic          data_ok,
  input  logic [31:0]   rdata,
  input  logic          flush,
  output logic          load_pending,
  output logic          resp_err
);
  localparam int PTR_W = (CNT_W > 1) ? CNT_W - 1 : 1;
  localparam logic [CNT_W:0] FULL = (CNT_W+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic        req;
    logic [4:0]  load_op;
    logic [31:0] result;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        ex;
    logic        done;
    logic [31:0] data;
  } ent_t;

  ent_t             ent_q [DEPTH];
  ent_t             ent_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] disc_q, disc_d;
  logic             resp_err_q, resp_err_d;

  logic             resp_hit;
  logic [PTR_W-1:0] resp_idx;
  logic [CNT_W-1:0] unmatched;
  logic             lp;
  logic [PTR_W-1:0] scan_idx;

  logic [CNT_W:0]   occ;
  logic             outv;
  logic             push;
  logic             pop;
  logic             consumed;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [31:0]      wdata;

  // oldest unanswered request, count of them, pending loads
  always_comb begin
    resp_hit  = 1'b0;
    resp_idx  = '0;
    unmatched = '0;
    lp        = 1'b0;
    scan_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if (ent_q[scan_idx].req && !ent_q[scan_idx].done) begin
          unmatched = unmatched + 1'b1;
          if (!resp_hit) begin
            resp_hit = 1'b1;
            resp_idx = scan_idx;
          end
        end
        if (ent_q[scan_idx].load_op != '0
            && !ent_q[scan_idx].done) begin
          lp = 1'b1;
        end
      end
    end
  end

  // discards still hold request slots downstream
  assign occ = {1'b0, count_q} + {1'b0, disc_q};
  assign io.in_ready = !flush && (occ < FULL);
  assign outv = (count_q != '0)
                && ent_q[head_q].done && !flush;
  assign io.out_valid = outv;
  assign push = io.in_valid && io.in_ready;
  assign pop  = outv && io.out_ready;

  always_comb begin
    byte_v = ent_q[head_q].data[8*ent_q[head_q].result[1:0] +: 8];
    half_v = ent_q[head_q].data[16*ent_q[head_q].result[1] +: 16];
    wdata  = ent_q[head_q].result;
    unique case (1'b1)
      ent_q[head_q].load_op[4]: wdata = {{24{byte_v[7]}}, byte_v};
      ent_q[head_q].load_op[3]: wdata = {24'b0, byte_v};
      ent_q[head_q].load_op[2]: wdata = {{16{half_v[15]}}, half_v};
      ent_q[head_q].load_op[1]: wdata = {16'b0, half_v};
      ent_q[head_q].load_op[0]: wdata = ent_q[head_q].data;
      default:                  wdata = ent_q[head_q].result;
    endcase
  end

  assign io.out_pc       = ent_q[head_q].pc;
  assign io.out_rf_waddr = ent_q[head_q].rf_waddr;
  assign io.out_ex       = ent_q[head_q].ex;
  assign io.out_rf_we    = ent_q[head_q].rf_we && outv
                           && !ent_q[head_q].ex;
  assign io.out_rf_wdata = wdata;
  assign load_pending    = lp;
  assign resp_err        = resp_err_q;

  always_comb begin
    ent_d      = ent_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    disc_d     = disc_q;
    resp_err_d = resp_err_q;
    consumed   = 1'b0;

    // responses retire discards first, then match in order
    if (data_ok) begin
      if (disc_q != '0) begin
        disc_d   = disc_q - 1'b1;
        consumed = 1'b1;
      end else if (resp_hit) begin
        ent_d[resp_idx].data = rdata;
        ent_d[resp_idx].done = 1'b1;
        consumed             = 1'b1;
      end else begin
        resp_err_d = 1'b1;
      end
    end

    if (flush) begin
      count_d = '0;
      tail_d  = head_q;
      disc_d  = disc_q + unmatched - CNT_W'(consumed);
    end else begin
      if (push) begin
        ent_d[tail_q].pc       = io.in_pc;
        ent_d[tail_q].req      = io.in_req && !io.in_ex;
        ent_d[tail_q].load_op  = io.in_load_op;
        ent_d[tail_q].result   = io.in_result;
        ent_d[tail_q].rf_we    = io.in_rf_we;
        ent_d[tail_q].rf_waddr = io.in_rf_waddr;
        ent_d[tail_q].ex       = io.in_ex;
        ent_d[tail_q].done     = !(io.in_req && !io.in_ex);
        ent_d[tail_q].data     = '0;
        tail_d = tail_q + 1'b1;
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      disc_q     <= '0;
      resp_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      disc_q     <= disc_d;
      resp_err_q <= resp_err_d;
      ent_q      <= ent_d;
    end
  end
endmodule

// File: doc/mem_stage_oq.md
MEM_STAGE_OQ -- requirements
Module: mem_stage_oq

Interface
REQ-001 Parameter DEPTH, default 4, in-flight MEM-stage entries (power of 2, 2..8).
REQ-002 Parameter CNT_W, default 3, counter width, equals log2(DEPTH)+1.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  EX presents an instruction.
REQ-006 in_ready  out  1  stage accepts; a push occurs when in_valid && in_ready.
REQ-007 in_pc  in  32  instruction PC.
REQ-008 in_req  in  1  instruction issued a data-memory request in EX.
REQ-009 in_load_op  in  5  one-hot {ld.b, ld.bu, ld.h, ld.hu, ld.w}; zero means not a load.
REQ-010 in_result  in  32  ALU result or address; bits [1:0] select byte/halfword.
REQ-011 in_rf_we, in_rf_waddr  in  1, 5  register write enable and address.
REQ-012 in_ex  in  1  instruction carries an exception.
REQ-013 data_ok  in  1  one in-order memory response this cycle.
REQ-014 rdata  in  32  response data, valid with data_ok.
REQ-015 flush  in  1  WB exception/ertn/tlb refetch; cancels all entries.
REQ-016 out_valid  out  1  head entry is complete.
REQ-017 out_ready  in  1  WB accepts; a pop occurs when out_valid && out_ready.
REQ-018 out_pc, out_rf_we, out_rf_waddr, out_rf_wdata, out_ex  out  32, 1, 5, 32, 1  head entry fields.
REQ-019 load_pending  out  1  some queued load has no data yet; drives the ID hazard stall.
REQ-020 resp_err  out  1  sticky; set when a data_ok arrives that matches nothing.

Function
REQ-021 Storage is a circular FIFO of DEPTH entries with head, tail and count; pointers wrap modulo DEPTH.
- Each entry holds pc, req (forced to 0 when in_ex=1), load_op, result, rf_we, rf_waddr, ex, done, data.
REQ-022 Entry done flag at push:
- done=1 if req=0.
- done=0 if req=1; it is set by the matching data_ok.
REQ-023 Responses match in order:
- A resp pointer tracks the oldest entry with req=1 && done=0.
- data_ok writes rdata to that entry and sets done.
- An entry pushed in cycle t cannot match a data_ok in cycle t.
REQ-024 in_ready = !flush && (count < DEPTH).
- No combinational path from out_ready.
- Push and pop in the same cycle are legal whenever count < DEPTH.
REQ-025 out_valid = count != 0 && head.done && !flush.
REQ-026 Result latency: the earliest cycle a pushed entry can reach the output is the cycle after the push (req=0), or the cycle after its data_ok (req=1).
REQ-027 out_rf_wdata:
- load_op == 0: equals result.
- Otherwise, the extracted value of head.data:
  - byte = data[8*result[1:0] +: 8]
  - halfword = data[16*result[1] +: 16]
  - ld.b / ld.h sign-extend; ld.bu / ld.hu zero-extend; ld.w is the full word.
REQ-028 out_rf_we = head.rf_we && out_valid && !head.ex.
REQ-029 load_pending = 1 iff any valid entry has load_op != 0 && done == 0.
REQ-030 Flush:
- Next cycle count=0 and head=tail.
- discard_cnt loads the number of req entries with done=0, minus 1 if data_ok is also asserted in the flush cycle.
- Pushes and pops are suppressed in the flush cycle.
REQ-031 While discard_cnt > 0, each data_ok decrements discard_cnt and is dropped, never written to a new entry.
REQ-032 A data_ok with discard_cnt == 0 and no unmatched req entry sets resp_err and changes no other state.
REQ-033 Request limit: outstanding requests (unmatched req entries + discard_cnt) never exceed DEPTH. In_ready is additionally low when discard_cnt + count == DEPTH.

Reset
REQ-034 On reset:
- count, head, tail, discard_cnt, resp_err, and all done/valid state clear to 0.
- out_valid=0, out_rf_we=0, load_pending=0, in_ready=1 from the first cycle after reset.
- Datapath outputs are don't-care but are driven 0.
REQ-035 Reset mid-operation discards all entries and pending discards; later stray data_ok sets resp_err.

Verification
REQ-036 Non-memory ALU op (in_result=0x1234, rf_waddr=5) pushed at t -> out_valid at t+1, out_rf_wdata=0x1234, out_rf_we=1.
REQ-037 ld.b with result[1:0]=3, data_ok at t+3 with rdata=0x80FF_0000 -> out_rf_wdata=0xFFFF_FF80 at t+4; load_pending high t+1..t+3.
REQ-038 Four back-to-back loads, out_ready=0 -> in_ready=0 after the fourth; four data_ok in order land in entries 0..3.
- Popping one restores in_ready the next cycle.
- Pointers wrap correctly on the fifth push.
REQ-039 Two loads outstanding, flush with a simultaneous data_ok -> discard_cnt=1; the next data_ok is dropped.
- A new load pushed afterward receives only the following data_ok.
REQ-040 data_ok with an empty queue and discard_cnt=0 -> resp_err=1 and remains set until reset.
REQ-041 Entry with in_ex=1, in_req=1 -> done at push, out_ex=1, out_rf_we=0, and it consumes no data_ok.
